// File: rtl/rotate_game_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rotate_pkg
// Purpose : Shared types and the cell-source mapping for the board and piece
//           rotators.
//           - rot_mode_t  : rotation selector (R0 / CW90 / R180 / CCW90)
//           - rot_state_t : sequencer states
//           - rot_src_xy  : for a destination cell (x', y'), returns the
//                           source cell (ox, oy) of a W x H input grid
// Revision: 1.0  initial release
// ============================================================================
package rotate_pkg;

   typedef enum logic [1:0] {
      ROT_0     = 2'd0,
      ROT_CW90  = 2'd1,
      ROT_180   = 2'd2,
      ROT_CCW90 = 2'd3
   } rot_mode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      COLS    = 2'd2,
      DONE    = 2'd3
   } rot_state_t;

   typedef struct packed {
      int ox;
      int oy;
   } rot_xy_t;

   // new[x][y] = old[ox][oy]; w/h are the dimensions of the *input* grid.
   function automatic rot_xy_t rot_src_xy(input rot_mode_t mode,
                                          input int x, input int y,
                                          input int w, input int h);
      rot_xy_t r;
      case (mode)
         ROT_CW90:  begin r.ox = y;         r.oy = h - 1 - x; end
         ROT_180:   begin r.ox = w - 1 - x; r.oy = h - 1 - y; end
         ROT_CCW90: begin r.ox = w - 1 - y; r.oy = x;         end
         default:   begin r.ox = x;         r.oy = y;         end
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rotate_game_seq_piece_grid.sv
`default_nettype none
// ============================================================================
// Module  : rotate_piece_grid
// Purpose : Combinational GRID x GRID piece rotator.
// Ports   : mode      in  rotation selector
//           piece_in  in  piece_in[x][y]
//           piece_out out rotated piece, piece_out[x'][y']
// Revision: 1.0  initial release
// ============================================================================
module rotate_piece_grid
   import rotate_pkg::*;
#(
   parameter int GRID = 4
) (
   input  rot_mode_t                   mode,
   input  logic [GRID-1:0][GRID-1:0]   piece_in,
   output logic [GRID-1:0][GRID-1:0]   piece_out
);

   localparam int GW = (GRID > 1) ? $clog2(GRID) : 1;

   rot_xy_t src;

   always_comb begin
      piece_out = '0;
      src       = '0;
      for (int x = 0; x < GRID; x++) begin
         for (int y = 0; y < GRID; y++) begin
            src = rot_src_xy(mode, x, y, GRID, GRID);
            // Square grid: every source index is in range for any mode.
            piece_out[x][y] = piece_in[src.ox[GW-1:0]][src.oy[GW-1:0]];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rotate_game_seq.sv
`default_nettype none
// ============================================================================
// Module  : rotate_game_seq
// Purpose : Multi-cycle rotator for the game board and active piece.
//           A start snapshot is taken in IDLE; the piece and its position are
//           rotated in CAPTURE; the board is rebuilt one output column per
//           cycle in COLS; DONE pulses done_o and raises valid_o.
// Ports   : GAME_clk / GAME_reset_n   clock, async active-low reset
//           start_i, rot_mode_i       request and rotation mode
//           piece_i, piece_x_i/y_i    piece grid and top-left position
//           screen_i                  board, screen_i[x][y]
//           ready_o, busy_o           FSM idle / running
//           done_o, valid_o           completion pulse / held result valid
//           out_w_o, out_h_o          rotated board dimensions
//           piece_o, piece_x_o/y_o    rotated piece and position
//           pos_err_o                 input position off-board
//           screen_o                  rotated board in a D x D store
// Revision: 1.0  initial release
// ============================================================================
module rotate_game_seq
   import rotate_pkg::*;
#(
   parameter int GRID    = 4,
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   localparam int D      = (BOARD_W > BOARD_H) ? BOARD_W : BOARD_H
) (
   input  logic                              GAME_clk,
   input  logic                              GAME_reset_n,
   input  logic                              start_i,
   input  rot_mode_t                         rot_mode_i,
   input  logic [GRID-1:0][GRID-1:0]         piece_i,
   input  logic [$clog2(BOARD_W)-1:0]        piece_x_i,
   input  logic [$clog2(BOARD_H)-1:0]        piece_y_i,
   input  logic [BOARD_W-1:0][BOARD_H-1:0]   screen_i,
   output logic                              ready_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              valid_o,
   output logic [$clog2(D+1)-1:0]            out_w_o,
   output logic [$clog2(D+1)-1:0]            out_h_o,
   output logic [GRID-1:0][GRID-1:0]         piece_o,
   output logic [$clog2(D)-1:0]              piece_x_o,
   output logic [$clog2(D)-1:0]              piece_y_o,
   output logic                              pos_err_o,
   output logic [D-1:0][D-1:0]               screen_o
);

   localparam int XW = $clog2(BOARD_W);
   localparam int YW = $clog2(BOARD_H);
   localparam int OW = $clog2(D + 1);
   localparam int PW = $clog2(D);

   rot_state_t                       state;
   rot_mode_t                        snap_mode;
   logic [BOARD_W-1:0][BOARD_H-1:0]  snap_screen;
   logic [GRID-1:0][GRID-1:0]        snap_piece;
   logic [XW-1:0]                    snap_px;
   logic [YW-1:0]                    snap_py;
   logic [PW-1:0]                    col;

   logic [GRID-1:0][GRID-1:0]        piece_rot;
   logic                             pos_bad;
   int                               px;
   int                               py;
   int                               nx;
   int                               ny;
   logic [OW-1:0]                    rot_w;
   logic [OW-1:0]                    rot_h;
   logic [D-1:0]                     col_data;
   rot_xy_t                          src;

   assign ready_o = (state == IDLE);
   assign busy_o  = (state != IDLE);

   rotate_piece_grid #(
      .GRID      (GRID)
   ) u_piece_grid (
      .mode      (snap_mode),
      .piece_in  (snap_piece),
      .piece_out (piece_rot)
   );

   // Rotated position and board dimensions from the snapshot. Arithmetic is
   // in int so an off-board position cannot wrap into a plausible value.
   always_comb begin
      px      = int'(snap_px);
      py      = int'(snap_py);
      pos_bad = (px > BOARD_W - GRID) || (py > BOARD_H - GRID);
      case (snap_mode)
         ROT_CW90:  begin nx = BOARD_H - GRID - py; ny = px;                  end
         ROT_180:   begin nx = BOARD_W - GRID - px; ny = BOARD_H - GRID - py; end
         ROT_CCW90: begin nx = py;                  ny = BOARD_W - GRID - px; end
         default:   begin nx = px;                  ny = py;                  end
      endcase
      if (pos_bad) begin
         nx = 0;
         ny = 0;
      end
      if ((snap_mode == ROT_CW90) || (snap_mode == ROT_CCW90)) begin
         rot_w = OW'(BOARD_H);
         rot_h = OW'(BOARD_W);
      end else begin
         rot_w = OW'(BOARD_W);
         rot_h = OW'(BOARD_H);
      end
   end

   // One output column: rows at or beyond out_h_o stay 0 so the unused part
   // of the square store never holds stale data.
   always_comb begin
      col_data = '0;
      src      = '0;
      for (int y = 0; y < D; y++) begin
         src = rot_src_xy(snap_mode, int'(col), y, BOARD_W, BOARD_H);
         if ((y < int'(out_h_o)) &&
             (src.ox >= 0) && (src.ox < BOARD_W) &&
             (src.oy >= 0) && (src.oy < BOARD_H)) begin
            col_data[y] = snap_screen[src.ox[XW-1:0]][src.oy[YW-1:0]];
         end
      end
   end

   always_ff @(posedge GAME_clk or negedge GAME_reset_n) begin
      if (!GAME_reset_n) begin
         state       <= IDLE;
         snap_mode   <= ROT_0;
         snap_screen <= '0;
         snap_piece  <= '0;
         snap_px     <= '0;
         snap_py     <= '0;
         col         <= '0;
         done_o      <= 1'b0;
         valid_o     <= 1'b0;
         pos_err_o   <= 1'b0;
         out_w_o     <= '0;
         out_h_o     <= '0;
         piece_o     <= '0;
         piece_x_o   <= '0;
         piece_y_o   <= '0;
         screen_o    <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  snap_mode   <= rot_mode_i;
                  snap_screen <= screen_i;
                  snap_piece  <= piece_i;
                  snap_px     <= piece_x_i;
                  snap_py     <= piece_y_i;
                  valid_o     <= 1'b0;
                  screen_o    <= '0;
                  state       <= CAPTURE;
               end
            end
            CAPTURE: begin
               piece_o   <= piece_rot;
               piece_x_o <= PW'(nx);
               piece_y_o <= PW'(ny);
               pos_err_o <= pos_bad;
               out_w_o   <= rot_w;
               out_h_o   <= rot_h;
               col       <= '0;
               state     <= COLS;
            end
            COLS: begin
               screen_o[col] <= col_data;
               if (OW'(col) == out_w_o - OW'(1)) begin
                  state <= DONE;
               end else begin
                  col <= col + PW'(1);
               end
            end
            DONE: begin
               done_o  <= 1'b1;
               valid_o <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
